// File: rtl/mem_bist_master.sv
// Memory self-test initiator: writes seed^addr everywhere, reads back,
// compares and reports a pass/fail summary over a valid/ready port.
module mem_bist_master #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic [WIDTH-1:0]      seed,
    output logic                  valid,
    input  logic                  ready,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic [WIDTH-1:0]      seed_q;
    logic                  hs;
    logic                  mism;
    logic [ADDR_WIDTH-1:0] addr_nx;

    // Address is zero-extended or truncated to the data width.
    function automatic logic [WIDTH-1:0] pat(
        input logic [WIDTH-1:0]      s,
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [WIDTH+ADDR_WIDTH-1:0] w;
        w = {{WIDTH{1'b0}}, a};
        return s ^ w[WIDTH-1:0];
    endfunction

    assign hs      = valid && ready;
    assign addr_nx = addr + ADDR_WIDTH'(1);
    assign mism    = (rdata != pat(seed_q, addr));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state          <= S_IDLE;
            seed_q         <= '0;
            valid          <= 1'b0;
            wr_rd          <= 1'b0;
            addr           <= '0;
            wdata          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_WRITE;
                        seed_q         <= seed;
                        valid          <= 1'b1;
                        wr_rd          <= 1'b1;
                        busy           <= 1'b1;
                        addr           <= '0;
                        wdata          <= seed;
                        err_count      <= '0;
                        pass           <= 1'b0;
                        first_err_addr <= '0;
                    end
                end
                S_WRITE: begin
                    if (hs) begin
                        if (addr == LAST) begin
                            state <= S_READ;
                            wr_rd <= 1'b0;
                            addr  <= '0;
                            wdata <= '0;
                        end else begin
                            addr  <= addr_nx;
                            wdata <= pat(seed_q, addr_nx);
                        end
                    end
                end
                S_READ: begin
                    if (hs) begin
                        if (mism) begin
                            err_count <= err_count + (ADDR_WIDTH+1)'(1);
                            if (err_count == '0)
                                first_err_addr <= addr;
                        end
                        // pass must already reflect this final compare
                        if (addr == LAST) begin
                            state <= S_DONE;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            addr  <= '0;
                            pass  <= (err_count == '0) && !mism;
                        end else begin
                            addr <= addr_nx;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_master.sv
// Scoreboard bench for mem_bist_master with a behavioural memory,
// random seeds, injected read faults and back-pressure.
module tb_mem_bist_master;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  seed = '0;
    logic          valid;
    logic          ready = 1'b1;
    logic          wr_rd;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr;

    typedef struct {
        bit wr;
        int a;
        int d;
    } txn_t;

    typedef struct {
        int errs;
        int first;
        int ok;
        int lat;
    } res_t;

    txn_t exp_q[$];
    res_t res_q[$];

    logic [W-1:0] mem [D];
    bit           corrupt [D];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int req_idx = 0;
    int stall_left = 0;
    bit stall_mode = 0;
    bit hold = 0;

    mem_bist_master #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .res(res),
        .start(start),
        .seed(seed),
        .valid(valid),
        .ready(ready),
        .wr_rd(wr_rd),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rdata = mem[addr] ^ W'(corrupt[addr]);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, expv, cyc);
        end
    endtask

    // Responder: memory array plus ready pattern.
    initial begin
        bit           hs;
        bit           w;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        for (int i = 0; i < D; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            hs = valid && ready;
            w  = wr_rd;
            a  = addr;
            d  = wdata;
            @(posedge clk);
            #1;
            if (hs) begin
                if (w) mem[a] = d;
                req_idx++;
                stall_left = (stall_mode && req_idx % 4 == 3) ? 3 : 0;
            end else if (stall_left > 0) begin
                stall_left--;
            end
            ready = (stall_left == 0) && !hold;
        end
    end

    // Monitor: pops expectations whenever the DUT presents something.
    initial begin
        bit            prev_stall;
        logic          pw;
        logic [AW-1:0] pa;
        logic [W-1:0]  pd;
        txn_t          t;
        res_t          r;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (!res) begin
                prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                chk("valid_drop", valid, 1);
                chk("stall_hold", {wr_rd, addr, wdata}, {pw, pa, pd});
            end
            prev_stall = valid && !ready;
            pw = wr_rd;
            pa = addr;
            pd = wdata;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_request", 1, 0);
                end else begin
                    t = exp_q.pop_front();
                    chk("wr_rd", wr_rd, t.wr);
                    chk("addr", addr, t.a);
                    if (t.wr) chk("wdata", wdata, t.d);
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    chk("err_count", err_count, r.errs);
                    chk("first_err_addr", first_err_addr, r.first);
                    chk("pass", pass, r.ok);
                    chk("latency", cyc + 1 - start_cyc, r.lat);
                    chk("busy_at_done", busy, 0);
                    chk("lost_requests", exp_q.size(), 0);
                end
            end
        end
    end

    task automatic launch(input logic [W-1:0] s);
        seed = s;
        req_idx = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc = cyc;
        chk("start_valid", valid, 1);
        chk("start_busy", busy, 1);
        chk("start_addr", addr, 0);
        chk("start_wdata", wdata, s);
        chk("clr_err", err_count, 0);
        chk("clr_first", first_err_addr, 0);
        chk("clr_pass", pass, 0);
    endtask

    task automatic run(input logic [W-1:0] s, input bit stalls,
                       input bit pulse_mid);
        txn_t t;
        res_t r;
        bit   got;
        r.errs = 0;
        r.first = 0;
        for (int a = 0; a < D; a++) begin
            if (corrupt[a]) begin
                if (r.errs == 0) r.first = a;
                r.errs++;
            end
        end
        r.ok = (r.errs == 0);
        r.lat = 2 * D + 1;
        if (stalls)
            for (int i = 0; i < 2 * D; i++)
                if (i % 4 == 3) r.lat += 3;
        for (int a = 0; a < D; a++) begin
            t.wr = 1;
            t.a = a;
            t.d = int'(s ^ W'(a));
            exp_q.push_back(t);
        end
        for (int a = 0; a < D; a++) begin
            t.wr = 0;
            t.a = a;
            t.d = 0;
            exp_q.push_back(t);
        end
        res_q.push_back(r);
        stall_mode = stalls;
        launch(s);
        if (pulse_mid) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            seed = ~s;
            @(posedge clk);
            #1 start = 1'b0;
            seed = s;
        end
        got = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
            res_q.delete();
        end
        @(posedge clk);
        #1 chk("done_pulse", done, 0);
        for (int a = 0; a < D; a++) corrupt[a] = 0;
        stall_mode = 0;
    endtask

    task automatic reset_in_stall();
        txn_t t;
        bit   got;
        for (int a = 0; a < 5; a++) begin
            t.wr = 1;
            t.a = a;
            t.d = int'(8'h66 ^ W'(a));
            exp_q.push_back(t);
        end
        launch(8'h66);
        got = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (valid && ready && wr_rd && addr == 4) begin
                hold = 1;
                got = 1;
                break;
            end
        end
        chk("reach_addr4", got, 1);
        repeat (3) @(negedge clk);
        chk("stall_valid", valid, 1);
        chk("stall_addr", addr, 5);
        #2 res = 1'b0;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", addr, 0);
        exp_q.delete();
        res_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
        @(posedge clk);
        #1 res = 1'b1;
        hold = 0;
    endtask

    initial begin
        for (int a = 0; a < D; a++) corrupt[a] = 0;
        #3;
        chk("reset_outs",
            {valid, wr_rd, busy, done, pass}, 0);
        chk("reset_addr", addr, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_err", {err_count, first_err_addr}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 res = 1'b1;

        run(8'hA5, 0, 1);
        corrupt[3] = 1;
        corrupt[9] = 1;
        run(8'h5A, 1, 0);
        run(8'h00, 0, 0);
        corrupt[15] = 1;
        run(8'hC3, 0, 0);
        reset_in_stall();
        run(8'h3C, 0, 0);
        for (int k = 0; k < 6; k++) begin
            for (int a = 0; a < D; a++)
                corrupt[a] = ($urandom_range(7) == 0);
            run(W'($urandom), bit'($urandom_range(1)), bit'($urandom_range(1)));
        end
        chk("leftover_txn", exp_q.size(), 0);
        chk("leftover_res", res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bist_master.md
# mem_bist_master

Synthesizable initiator for the valid/ready memory interface (`clk`, `res`, `valid`, `ready`, `wr_rd`, `addr`, `wdata`, `rdata`). It drives the memory responder from the requester side, replacing the testbench BFM with a hardware self-test engine. On `start` it writes a seed-derived pattern to every location, reads every location back, compares against expected data, and reports a pass/fail summary.

## Interface
- `WIDTH`, default 8: data width of `wdata`, `rdata` and `seed`.
- `DEPTH`, default 16: number of locations tested, addresses 0 to DEPTH-1.
- `ADDR_WIDTH`, default 4: address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- `clk` input 1: single clock; all logic on its rising edge.
- `res` input 1: reset, asynchronous, active-low.
- `start` input 1: launch request, sampled in IDLE only.
- `seed` input WIDTH: pattern seed, captured on accepted `start`.
- `valid` output 1: request valid toward the memory.
- `ready` input 1: memory accepts or completes the request.
- `wr_rd` output 1: 1 = write, 0 = read.
- `addr` output ADDR_WIDTH: request address.
- `wdata` output WIDTH: write data.
- `rdata` input WIDTH: read data; valid in the handshake cycle of a read.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle completion pulse.
- `pass` output 1: 1 when the last run saw zero mismatches.
- `err_count` output ADDR_WIDTH+1: mismatch count of the last or current run.
- `first_err_addr` output ADDR_WIDTH: address of the first mismatch of the run.

## Operation
- Handshake: a transfer completes on a rising edge with `valid && ready`.
  - While `valid` is high and `ready` is low, `addr`, `wdata` and `wr_rd` stay stable.
  - `valid` never drops without a handshake.
- Expected data at address A: `seed_q ^ A`, with A zero-extended or truncated to WIDTH.
- FSM states:
  - **IDLE**: `valid` is 0. `start` = 1 moves to WRITE, captures `seed`, and clears `err_count`, `pass` and `first_err_addr`. `start` outside IDLE is ignored.
  - **WRITE**: `valid` = 1, `wr_rd` = 1, `wdata` = `seed_q ^ addr`.
    - On handshake with `addr < DEPTH-1`: `addr` increments.
    - On handshake with `addr == DEPTH-1`: go to READ with `addr` = 0.
  - **READ**: `valid` = 1, `wr_rd` = 0. On handshake, compare `rdata` to `seed_q ^ addr`.
    - On mismatch, `err_count` increments.
    - If `err_count` was 0 before this mismatch, `first_err_addr` loads `addr`.
    - At `addr == DEPTH-1`, go to DONE; otherwise `addr` increments.
  - **DONE**: one cycle with `valid` = 0, `done` = 1, `busy` = 0. `pass` loads `(err_count == 0)`, including the final compare. Then return to IDLE.
- `pass`, `err_count` and `first_err_addr` hold until the next accepted `start`.
- `err_count` width holds up to DEPTH mismatches, so no saturation is required.

## Timing
- Reset (async assert, synchronous release): state IDLE.
  - `valid`, `wr_rd`, `busy`, `done` and `pass` are 0.
  - `addr`, `wdata`, `err_count` and `first_err_addr` are 0.
- `start` sampled high in IDLE at edge N: `valid` = 1, `busy` = 1, `addr` = 0 from edge N+1.
- There are no bubbles: the next request is presented in the cycle after each handshake. This includes the WRITE to READ turn, where `valid` stays high.
- With `ready` tied to 1, a run occupies exactly 2·DEPTH cycles of `valid`. `done` pulses at cycle 2·DEPTH+1 after `start` is sampled.
- Back-pressure: each cycle of `ready` low adds one cycle. Stall length is unbounded, with no timeout.
- `rdata` is sampled only at a READ handshake edge and ignored otherwise.
- Reset mid-run: outputs return to reset values immediately and the run is abandoned. No `done` pulse is produced.
- `start` high in the DONE cycle is ignored. `start` is accepted in the following IDLE cycle.

## Test plan
- Reset during stall:
  - Stimulus: assert `res` = 0 during a WRITE stall at `addr` = 5.
  - Required: `valid`, `busy` and `addr` are 0 asynchronously; no `done`.
  - Stimulus: a fresh `start` after reset release.
  - Required: the run begins at `addr` = 0.
- Fault-free run:
  - Stimulus: memory `ready` = 1, `seed` = 8'hA5.
  - Required: writes of A5, A4, A7, ... to addresses 0 to 15.
  - Required: `done` 33 cycles after `start`, with `pass` = 1 and `err_count` = 0.
- Back-pressure:
  - Stimulus: `ready` low for 3 cycles on every 4th request.
  - Required: `addr`, `wdata` and `wr_rd` stable during each stall; no request lost or duplicated; `pass` = 1.
- Injected read faults:
  - Stimulus: memory responder corrupts reads at addresses 3 and 9 (bit 0 flipped).
  - Required: `err_count` = 2, `first_err_addr` = 3, `pass` = 0.
- Fault on last location:
  - Stimulus: corrupt only address 15.
  - Required: `err_count` = 1, `first_err_addr` = 15, `pass` = 0 in the `done` cycle.
- Start while busy:
  - Stimulus: `start` pulsed while `busy` = 1.
  - Required: ignored; the run completes normally.
  - Stimulus: a second run after `done` with `seed` = 8'h00.
  - Required: `pass`, `err_count` and `first_err_addr` are cleared at the new `start`, and `wdata` equals `addr`.
